counter_mod: RTL and testbench

Parametrised modulo-N up/down counter: the general-purpose successor to the fixed 13-bit free-running counter. It adds a configurable width and modulus, a direction control, a synchronous parallel load, a terminal-count pulse and a sticky overflow flag. It drives address generators, sample/timebase dividers and event counters across the design. All state updates on the falling edge of `clock`.

---
 rtl/counter_mod.sv | 77 +++++++
 tb/tb_counter_mod.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/counter_mod.sv
// Parametrised modulo-MODULUS up/down counter with load, terminal-count pulse and sticky overflow.
// Define COUNTER_MOD_SATURATE_EN to saturate at the limits instead of wrapping.
module counter_mod #(
  parameter int WIDTH   = 13,
  parameter int MODULUS = 8192
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam longint MOD_L   = longint'(MODULUS);
  localparam longint RANGE_L = longint'(1) << WIDTH;

  if (WIDTH < 1 || MOD_L < 2 || MOD_L > RANGE_L) begin : g_bad_params
    $error("counter_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  // Terminal value; all-ones when MODULUS == 2**WIDTH, so no WIDTH+1 carry is needed.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_next;
  logic             hit;

  always_comb begin
    count_next = count;
    hit        = 1'b0;
    if (load) begin
      count_next = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (count == MAX_VAL) begin
          hit = 1'b1;
`ifdef COUNTER_MOD_SATURATE_EN
          count_next = MAX_VAL;
`else
          count_next = '0;
`endif
        end else begin
          count_next = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          hit = 1'b1;
`ifdef COUNTER_MOD_SATURATE_EN
          count_next = '0;
`else
          count_next = MAX_VAL;
`endif
        end else begin
          count_next = count - 1'b1;
        end
      end
    end
  end

  // A wrap/limit event on the same edge as clear_ovf leaves the flag set.
  always_ff @(negedge clock) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_next;
      tc    <= hit;
      ovf   <= hit | (ovf & ~clear_ovf);
    end
  end

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod: two instances (4-bit mod 10, 3-bit mod 8) share stimulus
// and are compared every falling edge against an arithmetic reference model.
module tb_counter_mod;

  // ---------------- clock / reset block ----------------
  logic clock = 1'b1;
  always #5 clock = ~clock;

  logic       reset     = 1'b1;
  logic       enable    = 1'b0;
  logic       up_down   = 1'b1;
  logic       load      = 1'b0;
  logic       clear_ovf = 1'b0;
  logic [3:0] lv_a      = '0;
  logic [2:0] lv_b      = '0;

  logic [3:0] count_a;
  logic       tc_a, ovf_a;
  logic [2:0] count_b;
  logic       tc_b, ovf_b;

  counter_mod #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv_a), .clear_ovf(clear_ovf), .count(count_a), .tc(tc_a), .ovf(ovf_a)
  );

  counter_mod #(.WIDTH(3), .MODULUS(8)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv_b), .clear_ovf(clear_ovf), .count(count_b), .tc(tc_b), .ovf(ovf_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

`ifdef COUNTER_MOD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int         m_count [2];
  bit         m_tc    [2];
  bit         m_ovf   [2];
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference: step in plain integers, detect leaving [0, modv), then wrap or clamp.
  function automatic void model_step(input int i, input int modv, input int lv);
    int nxt;
    bit hit;
    if (reset) begin
      m_count[i] = 0;
      m_tc[i]    = 1'b0;
      m_ovf[i]   = 1'b0;
      return;
    end
    hit = 1'b0;
    if (load) begin
      m_count[i] = (lv < modv) ? lv : modv - 1;
    end else if (enable) begin
      nxt = up_down ? m_count[i] + 1 : m_count[i] - 1;
      hit = (nxt < 0) || (nxt >= modv);
      if (SAT) nxt = (nxt < 0) ? 0 : (nxt >= modv ? modv - 1 : nxt);
      else     nxt = (nxt + modv) % modv;
      m_count[i] = nxt;
    end
    m_tc[i]  = hit;
    m_ovf[i] = hit || (m_ovf[i] && !clear_ovf);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit r, input bit l, input int lv, input bit en, input bit ud,
                       input bit co);
    reset     = r;
    load      = l;
    lv_a      = 4'(lv);
    lv_b      = 3'(lv);
    enable    = en;
    up_down   = ud;
    clear_ovf = co;
  endtask

  // One falling edge, then compare both instances against the model.
  task automatic tick();
    @(negedge clock);
    #1;
    model_step(0, 10, int'(lv_a));
    model_step(1, 8, int'(lv_b));
    check("a_count", 32'(count_a), 32'(m_count[0]));
    check("a_tc",    32'(tc_a),    32'(m_tc[0]));
    check("a_ovf",   32'(ovf_a),   32'(m_ovf[0]));
    check("b_count", 32'(count_b), 32'(m_count[1]));
    check("b_tc",    32'(tc_b),    32'(m_tc[1]));
    check("b_ovf",   32'(ovf_b),   32'(m_ovf[1]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] e;
    int         k;

    // Reset for two edges.
    drive(1, 0, 0, 0, 1, 0);
    tick();
    tick();
    check("reset_count", 32'(count_a), 0);
    check("reset_ovf",   32'(ovf_a),   0);

    // Up-count 12 edges from 0: wrap at 10 (or saturate at 9).
    for (int j = 1; j <= 12; j++) exp_q.push_back(4'(SAT ? (j > 9 ? 9 : j) : j % 10));
    drive(0, 0, 0, 1, 1, 0);
    k = 1;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check("up_seq_count", 32'(count_a), 32'(e));
      check("up_seq_tc",    32'(tc_a),    32'(SAT ? (k >= 10) : (k == 10)));
      check("up_seq_ovf",   32'(ovf_a),   32'(k >= 10));
      k++;
    end

    // Down-count through zero after loading 1.
    drive(0, 1, 1, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("down_zero", 32'(count_a), 0);
    tick();
    check("down_wrap_count", 32'(count_a), SAT ? 0 : 9);
    check("down_wrap_tc",    32'(tc_a),    1);
    tick();
    check("down_next_count", 32'(count_a), SAT ? 0 : 8);
    check("down_next_tc",    32'(tc_a),    SAT ? 1 : 0);

    // Load clamp beats enable; then reset beats load.
    drive(0, 1, 14, 1, 1, 0);
    tick();
    check("clamp_count", 32'(count_a), 9);
    check("clamp_tc",    32'(tc_a),    0);
    drive(1, 1, 5, 1, 1, 0);
    tick();
    check("reset_over_load", 32'(count_a), 0);

    // Sticky race: wrap and clear on the same edge, then clear alone.
    drive(0, 1, 9, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 1, 1);
    tick();
    check("race_ovf_set", 32'(ovf_a), 1);
    drive(0, 0, 0, 0, 1, 1);
    tick();
    check("race_ovf_clr", 32'(ovf_a), 0);

    // Full-range modulus on instance b: 9 up steps from reset.
    drive(1, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 1, 0);
    for (int j = 1; j <= 9; j++) begin
      tick();
      check("full_range_count", 32'(count_b), SAT ? (j > 7 ? 7 : j) : j % 8);
      check("full_range_tc",    32'(tc_b),    SAT ? (j >= 8) : (j == 8));
    end

    // Saturate-build scenario (load 8, up 4), also valid as a wrap check in the default build.
    drive(0, 1, 8, 0, 1, 0);
    tick();
    drive(0, 0, 0, 1, 1, 0);
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("load8_up_count", 32'(count_a), SAT ? 9 : (8 + j) % 10);
      check("load8_up_tc",    32'(tc_a),    SAT ? (j >= 2) : (j == 2));
    end

    // Randomized phase.
    for (int j = 0; j < 400; j++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
      tick();
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
